// File: rtl/freq_meter_pkg.sv
// Shared types for the frequency meter: gate encodings, FSM states, averaging depth
// and gate scale factors.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        GATE_1S    = 2'b00,
        GATE_100MS = 2'b01,
        GATE_10MS  = 2'b10
    } gate_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_SCALE,
        S_OUT
    } state_e;

    localparam int unsigned AVG_DEPTH = 4;

    // The reserved code 2'b11 behaves as a 1 s gate.
    function automatic gate_e norm_gate(input logic [1:0] sel);
        case (sel)
            2'b01:   return GATE_100MS;
            2'b10:   return GATE_10MS;
            default: return GATE_1S;
        endcase
    endfunction

    function automatic int unsigned gate_scale(input gate_e g);
        case (g)
            GATE_100MS: return 10;
            GATE_10MS:  return 100;
            default:    return 1;
        endcase
    endfunction

endpackage

// File: rtl/freq_meter_core_schmitt.sv
// fm_schmitt: registers each ADC sample on the strobe, applies hysteresis and flags
// rising level crossings one clock after the strobe.
module fm_schmitt
    import freq_meter_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_stb,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_thr_hi,
    input  logic [DATA_W-1:0] i_thr_lo,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_vld,
    output logic              o_rise
);
    logic [DATA_W-1:0] r_sample;
    logic              r_level;
    logic              r_vld;
    logic              r_rise;
    logic              w_level_nxt;

    always_comb begin
        w_level_nxt = r_level;
        if (i_data >= i_thr_hi)
            w_level_nxt = 1'b1;
        else if (i_data <= i_thr_lo)
            w_level_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sample <= '0;
            r_level  <= 1'b0;
            r_vld    <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_vld  <= i_stb;
            r_rise <= i_stb & w_level_nxt & ~r_level;
            if (i_stb) begin
                r_sample <= i_data;
                r_level  <= w_level_nxt;
            end
        end
    end

    assign o_sample = r_sample;
    assign o_vld    = r_vld;
    assign o_rise   = r_rise;

endmodule

// File: rtl/freq_meter_core.sv
// freq_meter_core: ADC clock generation, gated edge counting and Vpp measurement.
// Optional FREQ_METER_AVG_EN reports the mean of the last AVG_DEPTH gate results.
module freq_meter_core
    import freq_meter_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CLK_HZ = 27_000_000,
    parameter int unsigned AD_DIV = 2,
    parameter int unsigned FREQ_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [1:0]        gate_sel,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic              ad_clk,
    input  logic [DATA_W-1:0] ad_data,
    output logic [FREQ_W-1:0] freq_hz,
    output logic [DATA_W-1:0] vpp,
    output logic              meas_valid,
    output logic              overflow,
    output logic              busy
);
    localparam int unsigned HALF       = AD_DIV / 2;
    localparam int unsigned DIV_W      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned GCNT_W     = $clog2(CLK_HZ);
    localparam int unsigned XW         = FREQ_W + 7;
    localparam int unsigned LOAD_1S    = CLK_HZ / gate_scale(GATE_1S) - 1;
    localparam int unsigned LOAD_100MS = CLK_HZ / gate_scale(GATE_100MS) - 1;
    localparam int unsigned LOAD_10MS  = CLK_HZ / gate_scale(GATE_10MS) - 1;

    logic [DIV_W-1:0]  r_div;
    logic              r_ad_clk;
    logic              w_div_end;
    logic              w_stb;

    assign w_div_end = (r_div == DIV_W'(HALF - 1));
    assign w_stb     = w_div_end & ~r_ad_clk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div    <= '0;
            r_ad_clk <= 1'b0;
        end else if (w_div_end) begin
            r_div    <= '0;
            r_ad_clk <= ~r_ad_clk;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    logic [DATA_W-1:0] w_sample;
    logic              w_vld;
    logic              w_rise;

    fm_schmitt #(.DATA_W(DATA_W)) u_schmitt (
        .clk      (clk),
        .rstn     (rstn),
        .i_stb    (w_stb),
        .i_data   (ad_data),
        .i_thr_hi (thr_hi),
        .i_thr_lo (thr_lo),
        .o_sample (w_sample),
        .o_vld    (w_vld),
        .o_rise   (w_rise)
    );

    state_e            r_state;
    gate_e             r_gsel;
    logic [GCNT_W-1:0] r_gcnt;
    logic [FREQ_W-1:0] r_cnt;
    logic              r_ovf;
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic              r_seen;
    logic [FREQ_W-1:0] r_freq;
    logic [DATA_W-1:0] r_vpp;
    logic              r_ovf_out;
    logic              r_valid;
    logic              r_busy;

    gate_e             w_gsel_nxt;
    logic [GCNT_W-1:0] w_gload;
    logic              w_start;
    logic [XW-1:0]     w_x;
    logic [XW-1:0]     w_x10;
    logic [XW-1:0]     w_prod;
    logic              w_sat;
    logic [FREQ_W-1:0] w_res;
    logic              w_ovf_nxt;
    logic [DATA_W-1:0] w_vpp;

    assign w_gsel_nxt = norm_gate(gate_sel);
    assign w_start    = en && ((r_state == S_IDLE) || (r_state == S_OUT));

    always_comb begin
        case (w_gsel_nxt)
            GATE_100MS: w_gload = GCNT_W'(LOAD_100MS);
            GATE_10MS:  w_gload = GCNT_W'(LOAD_10MS);
            default:    w_gload = GCNT_W'(LOAD_1S);
        endcase
    end

    // x10 = x<<3 + x<<1; x100 applies the same step twice
    always_comb begin
        w_x   = XW'(r_cnt);
        w_x10 = (w_x << 3) + (w_x << 1);
        case (r_gsel)
            GATE_100MS: w_prod = w_x10;
            GATE_10MS:  w_prod = (w_x10 << 3) + (w_x10 << 1);
            default:    w_prod = w_x;
        endcase
        w_sat     = |w_prod[XW-1:FREQ_W];
        w_res     = w_sat ? '1 : w_prod[FREQ_W-1:0];
        w_ovf_nxt = r_ovf | w_sat;
        w_vpp     = r_seen ? (r_max - r_min) : '0;
    end

`ifdef FREQ_METER_AVG_EN
    localparam int unsigned SUM_W = FREQ_W + 2;
    localparam int unsigned HCW   = $clog2(AVG_DEPTH);

    logic [AVG_DEPTH-2:0][FREQ_W-1:0] r_hist;
    logic [AVG_DEPTH-2:0]             r_hovf;
    logic [HCW-1:0]                   r_hcnt;
    logic [SUM_W-1:0]                 w_sum;
    logic                             w_hovf;

    always_comb begin
        w_sum  = SUM_W'(w_res);
        w_hovf = w_ovf_nxt;
        for (int unsigned i = 0; i < AVG_DEPTH - 1; i++) begin
            w_sum  = w_sum + SUM_W'(r_hist[i]);
            w_hovf = w_hovf | r_hovf[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_gsel    <= GATE_1S;
            r_gcnt    <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_min     <= '1;
            r_max     <= '0;
            r_seen    <= 1'b0;
            r_freq    <= '0;
            r_vpp     <= '0;
            r_ovf_out <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef FREQ_METER_AVG_EN
            r_hist    <= '0;
            r_hovf    <= '0;
            r_hcnt    <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: r_busy <= 1'b0;
                S_GATE: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt - GCNT_W'(1);
                        if (w_rise) begin
                            if (&r_cnt)
                                r_ovf <= 1'b1;
                            else
                                r_cnt <= r_cnt + FREQ_W'(1);
                        end
                        if (w_vld) begin
                            r_seen <= 1'b1;
                            if (w_sample < r_min) r_min <= w_sample;
                            if (w_sample > r_max) r_max <= w_sample;
                        end
                        if (r_gcnt == '0) begin
                            r_state <= S_SCALE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_SCALE: begin
                    r_state <= S_OUT;
`ifdef FREQ_METER_AVG_EN
                    r_hist <= {r_hist[AVG_DEPTH-3:0], w_res};
                    r_hovf <= {r_hovf[AVG_DEPTH-3:0], w_ovf_nxt};
                    if (r_hcnt == HCW'(AVG_DEPTH - 1)) begin
                        r_freq    <= w_sum[SUM_W-1:2];
                        r_vpp     <= w_vpp;
                        r_ovf_out <= w_hovf;
                        r_valid   <= 1'b1;
                    end else begin
                        r_hcnt <= r_hcnt + HCW'(1);
                    end
`else
                    r_freq    <= w_res;
                    r_vpp     <= w_vpp;
                    r_ovf_out <= w_ovf_nxt;
                    r_valid   <= 1'b1;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
            // Starting a gate overrides the idle/out handling above.
            if (w_start) begin
                r_state <= S_GATE;
                r_busy  <= 1'b1;
                r_gsel  <= w_gsel_nxt;
                r_gcnt  <= w_gload;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
                r_min   <= '1;
                r_max   <= '0;
                r_seen  <= 1'b0;
`ifdef FREQ_METER_AVG_EN
                if ((r_state == S_IDLE) || (w_gsel_nxt != r_gsel))
                    r_hcnt <= '0;
`endif
            end
        end
    end

    assign ad_clk     = r_ad_clk;
    assign freq_hz    = r_freq;
    assign vpp        = r_vpp;
    assign meas_valid = r_valid;
    assign overflow   = r_ovf_out;
    assign busy       = r_busy;

endmodule

// File: tb/tb_freq_meter_core.sv
// Bench for freq_meter_core: periodic ADC waveforms with random hysteresis noise,
// checked against expected edge counts per gate window.
`timescale 1ns/1ps
module tb_freq_meter_core;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned AD_DIV = 2;
    localparam int unsigned FREQ_W = 32;
    localparam int unsigned SAT4   = 15;

    logic              clk = 1'b0;
    logic              rstn;
    logic              en;
    logic [1:0]        gate_sel;
    logic [DATA_W-1:0] thr_hi;
    logic [DATA_W-1:0] thr_lo;
    logic [DATA_W-1:0] ad_data;
    logic              ad_clk, ad_clk4;
    logic [FREQ_W-1:0] freq_hz;
    logic [3:0]        freq4;
    logic [DATA_W-1:0] vpp, vpp4;
    logic              meas_valid, mv4;
    logic              overflow, ovf4;
    logic              busy, busy4;

    int n_err = 0;
    int n_chk = 0;

    int wv_const = 0;
    int wv_per   = 10;
    int wv_hi    = 5;
    int wv_H     = 255;
    int wv_L     = 0;
    int wv_noise = 0;
    int wv_ph    = 0;

    freq_meter_core #(.DATA_W(DATA_W), .CLK_HZ(CLK_HZ), .AD_DIV(AD_DIV), .FREQ_W(FREQ_W)) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .gate_sel(gate_sel), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .ad_clk(ad_clk), .ad_data(ad_data), .freq_hz(freq_hz), .vpp(vpp),
        .meas_valid(meas_valid), .overflow(overflow), .busy(busy)
    );

    freq_meter_core #(.DATA_W(DATA_W), .CLK_HZ(CLK_HZ), .AD_DIV(AD_DIV), .FREQ_W(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .en(en), .gate_sel(gate_sel), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .ad_clk(ad_clk4), .ad_data(ad_data), .freq_hz(freq4), .vpp(vpp4),
        .meas_valid(mv4), .overflow(ovf4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int unsigned scale_of(input logic [1:0] gs);
        case (gs)
            2'b01:   return 10;
            2'b10:   return 100;
            default: return 1;
        endcase
    endfunction

    // ADC model: a new sample after every falling edge of ad_clk.
    // Each period: H, high-band noise, L, low-band noise; noise never crosses the far threshold.
    initial begin
        ad_data = '0;
        forever begin
            @(negedge ad_clk);
            if (wv_const != 0)
                ad_data = 8'd128;
            else begin
                if (wv_ph == 0)
                    ad_data = 8'(wv_H);
                else if (wv_ph < wv_hi)
                    ad_data = (wv_noise != 0) ? 8'($urandom_range(wv_H, 97)) : 8'(wv_H);
                else if (wv_ph == wv_hi)
                    ad_data = 8'(wv_L);
                else
                    ad_data = (wv_noise != 0) ? 8'($urandom_range(159, wv_L)) : 8'(wv_L);
                wv_ph = (wv_ph + 1) % wv_per;
            end
        end
    end

    task automatic set_wave(input int cst, input int per, input int hi, input int h, input int l, input int noise);
        wv_const = cst;
        wv_per   = per;
        wv_hi    = hi;
        wv_H     = h;
        wv_L     = l;
        wv_noise = noise;
        wv_ph    = 0;
        tick(per * AD_DIV * 2 + 8);
    endtask

    task automatic wait_valid(input string tag, input int bound, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!meas_valid && n < bound);
        if (!meas_valid) check({tag, " timeout"}, 0, 1);
    endtask

    function automatic int unsigned exp_freq(input logic [1:0] gs);
        int unsigned sc, win;
        sc  = scale_of(gs);
        win = CLK_HZ / sc / AD_DIV;
        return (wv_const != 0) ? 0 : (win / wv_per) * sc;
    endfunction

    task automatic check_vals(input string tag, input int unsigned ef);
        int unsigned ev;
        ev = (wv_const != 0) ? 0 : (wv_H - wv_L);
        check({tag, " freq"}, freq_hz, ef);
        check({tag, " vpp"}, vpp, ev);
        check({tag, " ovf"}, overflow, 0);
        check({tag, " freq4"}, freq4, (ef > SAT4) ? SAT4 : ef);
        check({tag, " ovf4"}, ovf4, (ef > SAT4) ? 1 : 0);
    endtask

    task automatic measure(input string tag, input logic [1:0] gs, input int nres, output int unsigned ef);
        int n;
        int unsigned glen;
        glen     = CLK_HZ / scale_of(gs);
        ef       = exp_freq(gs);
        gate_sel = gs;
        en       = 1'b1;
        for (int r = 0; r < nres; r++) begin
            wait_valid(tag, int'(glen) * 2 + 10, n);
            check({tag, " latency"}, n, glen + 2);
            check_vals(tag, ef);
        end
        en = 1'b0;
        tick(3);
        check({tag, " idle"}, busy, 0);
    endtask

    initial begin
        int n, hi_cnt;
        int unsigned last_f, ef;
        logic [1:0] gs;
        int seen;
        int per_100[5] = '{2, 5, 10, 25, 50};

        rstn     = 1'b0;
        en       = 1'b0;
        gate_sel = 2'b00;
        thr_hi   = 8'd160;
        thr_lo   = 8'd96;
        tick(4);
        check("rst ad_clk", ad_clk, 0);
        check("rst freq", freq_hz, 0);
        check("rst vpp", vpp, 0);
        check("rst valid", meas_valid, 0);
        check("rst ovf", overflow, 0);
        check("rst busy", busy, 0);
        rstn = 1'b1;

        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ad_clk) seen++;
        end
        check("ad_clk duty", seen, 20 / 2);

        // 50 Hz square, 1 s gates back to back; gate_sel change mid-gate must be ignored
        set_wave(0, 10, 5, 255, 0, 0);
        gate_sel = 2'b00;
        en       = 1'b1;
        tick(1);
        check("sq busy", busy, 1);
        wait_valid("sq1", 3000, n);
        check("sq1 latency", n + 1, 1002);
        check_vals("sq1", 50);
        tick(300);
        gate_sel = 2'b10;
        wait_valid("sq2", 3000, n);
        check("sq2 latency", n + 300, 1002);
        check_vals("sq2", 50);
        en = 1'b0;
        tick(3);
        gate_sel = 2'b00;
        last_f   = 50;

        measure("sq100", 2'b01, 2, last_f);
        measure("gate11", 2'b11, 1, last_f);

        set_wave(1, 10, 5, 0, 0, 0);
        measure("const", 2'b01, 1, last_f);

        // Abort mid-gate: no result, previous outputs retained
        set_wave(0, 10, 5, 255, 0, 0);
        gate_sel = 2'b00;
        en       = 1'b1;
        tick(500);
        check("abort busy pre", busy, 1);
        en = 1'b0;
        tick(1);
        check("abort busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(1);
            if (meas_valid) seen++;
        end
        check("abort no valid", seen, 0);
        check("abort freq kept", freq_hz, last_f);

        for (int it = 0; it < 8; it++) begin
            gs = 2'($urandom_range(1, 2));
            if (gs == 2'b10)
                wv_per = 5;
            else
                wv_per = per_100[$urandom_range(0, 4)];
            hi_cnt = $urandom_range(1, wv_per - 1);
            set_wave(0, wv_per, hi_cnt, $urandom_range(160, 255), $urandom_range(0, 96), 1);
            measure("rnd", gs, 2, last_f);
        end

        // Reset mid-gate clears everything
        set_wave(0, 10, 5, 200, 20, 1);
        measure("pre-rst", 2'b01, 1, last_f);
        gate_sel = 2'b00;
        en       = 1'b1;
        tick(300);
        check("mid busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("mrst freq", freq_hz, 0);
        check("mrst vpp", vpp, 0);
        check("mrst ovf", overflow, 0);
        check("mrst busy", busy, 0);
        check("mrst ad_clk", ad_clk, 0);
        en = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
